// File: rtl/register_read_stage_pkg.sv
// Shared definitions for the register-read stage.
// Contents: datapath width, register count, bubble opcode pair, the registered
// instruction record handed to execute, and the operand forwarding rule.
package register_read_stage_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 16;
  localparam int unsigned REG_AW    = $clog2(REG_COUNT);
  localparam int unsigned OP_W      = 6;
  localparam int unsigned ALTOP_W   = 8;

  // Opcode pair that execute treats as "no operation".
  localparam logic [OP_W-1:0]    BUBBLE_OP    = '0;
  localparam logic [ALTOP_W-1:0] BUBBLE_ALTOP = '0;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [OP_W-1:0]    op;
    logic [ALTOP_W-1:0] altop;
    logic [REG_AW-1:0]  rd;
    logic [XLEN-1:0]    imm32;
    logic [XLEN-1:0]    rs_val;
    logic [XLEN-1:0]    rt_val;
  } rr_instr_t;

  localparam rr_instr_t BUBBLE = '{
    pc:     '0,
    op:     BUBBLE_OP,
    altop:  BUBBLE_ALTOP,
    rd:     '0,
    imm32:  '0,
    rs_val: '0,
    rt_val: '0
  };

  // Operand source, highest priority first: r0, the instruction in execute,
  // the writeback port landing this edge, then the register file.
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [REG_AW-1:0] idx,
    input logic [REG_AW-1:0] of_reg,
    input logic [XLEN-1:0]   of_val,
    input logic [REG_AW-1:0] wb_reg,
    input logic [XLEN-1:0]   wb_val,
    input logic [XLEN-1:0]   rf_val
  );
    logic [XLEN-1:0] val;
    if (idx == '0) begin
      val = '0;
    end else if (idx == of_reg) begin
      val = of_val;
    end else if (idx == wb_reg) begin
      val = wb_val;
    end else begin
      val = rf_val;
    end
    return val;
  endfunction

endpackage

// File: rtl/register_read_stage_if.sv
// Decode-to-register-read handshake bundle.
// master: decode side, drives dec_* and observes rr_ready.
// slave:  register-read stage, consumes dec_* and drives rr_ready.
interface register_read_stage_if;
  import register_read_stage_pkg::*;

  logic                dec_valid;
  logic [XLEN-1:0]     dec_pc;
  logic [XLEN-1:0]     dec_imm32;
  logic [OP_W-1:0]     dec_op;
  logic [ALTOP_W-1:0]  dec_altop;
  logic [REG_AW-1:0]   dec_rd;
  logic [REG_AW-1:0]   dec_rs;
  logic [REG_AW-1:0]   dec_rt;
  logic                rr_ready;

  modport master (
    output dec_valid, dec_pc, dec_imm32, dec_op, dec_altop, dec_rd, dec_rs, dec_rt,
    input  rr_ready
  );

  modport slave (
    input  dec_valid, dec_pc, dec_imm32, dec_op, dec_altop, dec_rd, dec_rs, dec_rt,
    output rr_ready
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 16 x 32 register file, two asynchronous read ports, one synchronous write port.
// Register 0 always reads zero and ignores writes.
// Ports: clk, rst (async, active-high, clears all entries), raddr_a/rdata_a,
// raddr_b/rdata_b, we/waddr/wdata.
module regfile_2r1w
  import register_read_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr_a,
  output logic [XLEN-1:0]   rdata_a,
  input  logic [REG_AW-1:0] raddr_b,
  output logic [XLEN-1:0]   rdata_b,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [XLEN-1:0]   wdata
);

  logic [XLEN-1:0] mem_q [REG_COUNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem_q[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem_q[raddr_b];

endmodule

// File: rtl/register_read_stage.sv
// Register-read pipeline stage: reads rs/rt with forwarding from execute and
// writeback, and registers the decoded instruction toward execute.
// Ports: i_clk, i_reset (async, active-high); dec (decode handshake, slave);
// exec_stall/exec_flush hold/squash; exec_of_reg/val forward from execute;
// exec_rd/exec_rd_val writeback port; rr_* registered instruction and
// operands; rr_bubbles counts inserted bubbles (wraps).
module register_read_stage
  import register_read_stage_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_reset,
  register_read_stage_if.slave  dec,
  input  logic                  exec_stall,
  input  logic                  exec_flush,
  input  logic [REG_AW-1:0]     exec_of_reg,
  input  logic [XLEN-1:0]       exec_of_val,
  input  logic [REG_AW-1:0]     exec_rd,
  input  logic [XLEN-1:0]       exec_rd_val,
  output logic [XLEN-1:0]       rr_pc,
  output logic [OP_W-1:0]       rr_op,
  output logic [ALTOP_W-1:0]    rr_altop,
  output logic [REG_AW-1:0]     rr_rd,
  output logic [XLEN-1:0]       rr_rs_val,
  output logic [XLEN-1:0]       rr_rt_val,
  output logic [XLEN-1:0]       rr_imm32,
  output logic [XLEN-1:0]       rr_bubbles
);

  logic [XLEN-1:0] rf_rs, rf_rt;
  logic [XLEN-1:0] rs_fwd, rt_fwd;
  rr_instr_t       rr_d, rr_q;
  logic [XLEN-1:0] bubbles_d, bubbles_q;

  // Writeback lands every edge with a nonzero target, independent of stall/flush.
  regfile_2r1w u_regfile (
    .clk     (i_clk),
    .rst     (i_reset),
    .raddr_a (dec.dec_rs),
    .rdata_a (rf_rs),
    .raddr_b (dec.dec_rt),
    .rdata_b (rf_rt),
    .we      (exec_rd != '0),
    .waddr   (exec_rd),
    .wdata   (exec_rd_val)
  );

  assign rs_fwd = fwd_operand(dec.dec_rs, exec_of_reg, exec_of_val, exec_rd, exec_rd_val, rf_rs);
  assign rt_fwd = fwd_operand(dec.dec_rt, exec_of_reg, exec_of_val, exec_rd, exec_rd_val, rf_rt);

  // Only stall gates decode, so there is no path from dec_valid back to rr_ready.
  assign dec.rr_ready = !exec_stall;

  always_comb begin
    rr_d      = rr_q;
    bubbles_d = bubbles_q;
    if (!exec_stall) begin
      if (exec_flush || !dec.dec_valid) begin
        rr_d      = BUBBLE;
        bubbles_d = bubbles_q + 32'd1;
      end else begin
        rr_d.pc     = dec.dec_pc;
        rr_d.op     = dec.dec_op;
        rr_d.altop  = dec.dec_altop;
        rr_d.rd     = dec.dec_rd;
        rr_d.imm32  = dec.dec_imm32;
        rr_d.rs_val = rs_fwd;
        rr_d.rt_val = rt_fwd;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_q      <= BUBBLE;
      bubbles_q <= '0;
    end else begin
      rr_q      <= rr_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign rr_pc      = rr_q.pc;
  assign rr_op      = rr_q.op;
  assign rr_altop   = rr_q.altop;
  assign rr_rd      = rr_q.rd;
  assign rr_rs_val  = rr_q.rs_val;
  assign rr_rt_val  = rr_q.rt_val;
  assign rr_imm32   = rr_q.imm32;
  assign rr_bubbles = bubbles_q;

endmodule

// File: tb/tb_register_read_stage.sv
// Bench for register_read_stage: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the stage.
module tb_register_read_stage;

  logic        i_clk;
  logic        i_reset;
  logic        exec_stall;
  logic        exec_flush;
  logic [3:0]  exec_of_reg;
  logic [31:0] exec_of_val;
  logic [3:0]  exec_rd;
  logic [31:0] exec_rd_val;
  logic [31:0] rr_pc;
  logic [5:0]  rr_op;
  logic [7:0]  rr_altop;
  logic [3:0]  rr_rd;
  logic [31:0] rr_rs_val;
  logic [31:0] rr_rt_val;
  logic [31:0] rr_imm32;
  logic [31:0] rr_bubbles;

  register_read_stage_if dif ();

  register_read_stage dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .dec         (dif),
    .exec_stall  (exec_stall),
    .exec_flush  (exec_flush),
    .exec_of_reg (exec_of_reg),
    .exec_of_val (exec_of_val),
    .exec_rd     (exec_rd),
    .exec_rd_val (exec_rd_val),
    .rr_pc       (rr_pc),
    .rr_op       (rr_op),
    .rr_altop    (rr_altop),
    .rr_rd       (rr_rd),
    .rr_rs_val   (rr_rs_val),
    .rr_rt_val   (rr_rt_val),
    .rr_imm32    (rr_imm32),
    .rr_bubbles  (rr_bubbles)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model of what execute should see.
  logic [31:0] m_regs [16];
  logic [31:0] m_pc, m_imm, m_rs, m_rt, m_bub;
  logic [5:0]  m_op;
  logic [7:0]  m_altop;
  logic [3:0]  m_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'd0;
    m_pc = 0; m_op = 0; m_altop = 0; m_rd = 0; m_imm = 0; m_rs = 0; m_rt = 0;
    m_bub = 0;
  endtask

  function automatic logic [31:0] m_operand(input logic [3:0] idx);
    if (idx == 4'd0) return 32'd0;
    if (idx == exec_of_reg) return exec_of_val;
    if (idx == exec_rd) return exec_rd_val;
    return m_regs[idx];
  endfunction

  task automatic check_all(input string tag);
    check({tag, " pc"},      rr_pc,               m_pc);
    check({tag, " op"},      {26'd0, rr_op},      {26'd0, m_op});
    check({tag, " altop"},   {24'd0, rr_altop},   {24'd0, m_altop});
    check({tag, " rd"},      {28'd0, rr_rd},      {28'd0, m_rd});
    check({tag, " imm32"},   rr_imm32,            m_imm);
    check({tag, " rs_val"},  rr_rs_val,           m_rs);
    check({tag, " rt_val"},  rr_rt_val,           m_rt);
    check({tag, " bubbles"}, rr_bubbles,          m_bub);
  endtask

  task automatic idle_inputs();
    exec_stall = 0; exec_flush = 0;
    exec_of_reg = 0; exec_of_val = 0; exec_rd = 0; exec_rd_val = 0;
    dif.dec_valid = 0; dif.dec_pc = 0; dif.dec_imm32 = 0; dif.dec_op = 0;
    dif.dec_altop = 0; dif.dec_rd = 0; dif.dec_rs = 0; dif.dec_rt = 0;
  endtask

  task automatic set_dec(input logic [31:0] pc, input logic [3:0] rs, input logic [3:0] rt);
    dif.dec_valid = 1;
    dif.dec_pc    = pc;
    dif.dec_rs    = rs;
    dif.dec_rt    = rt;
    dif.dec_op    = 6'($urandom_range(1, 63));
    dif.dec_altop = 8'($urandom);
    dif.dec_rd    = 4'($urandom);
    dif.dec_imm32 = $urandom;
  endtask

  // One clock with the current inputs; model predicts, DUT compared after the edge.
  task automatic cycle(input string tag);
    logic [31:0] rs_v, rt_v;
    #1;
    check({tag, " rr_ready"}, {31'd0, dif.rr_ready}, {31'd0, !exec_stall});
    rs_v = m_operand(dif.dec_rs);
    rt_v = m_operand(dif.dec_rt);
    if (!exec_stall) begin
      m_bub = m_bub + 1;
      if (exec_flush || !dif.dec_valid) begin
        m_pc = 0; m_op = 0; m_altop = 0; m_rd = 0; m_imm = 0; m_rs = 0; m_rt = 0;
      end else begin
        m_bub   = m_bub - 1;
        m_pc    = dif.dec_pc;
        m_op    = dif.dec_op;
        m_altop = dif.dec_altop;
        m_rd    = dif.dec_rd;
        m_imm   = dif.dec_imm32;
        m_rs    = rs_v;
        m_rt    = rt_v;
      end
    end
    if (exec_rd != 4'd0) m_regs[exec_rd] = exec_rd_val;
    @(posedge i_clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    idle_inputs();
    m_reset();
    i_reset = 0;
    #1 i_reset = 1;
    #2 check_all("reset");
    @(negedge i_clk);
    i_reset = 0;

    // Writeback then read through the register file.
    exec_rd = 5; exec_rd_val = 32'h1234;
    cycle("wb r5");
    exec_rd = 0; exec_rd_val = 0;
    set_dec(32'h4, 4'd5, 4'd0);
    cycle("read r5");
    check("read r5 explicit", rr_rs_val, 32'h1234);
    check("read r0 explicit", rr_rt_val, 32'h0);

    // Execute forward beats the writeback port.
    exec_of_reg = 3; exec_of_val = 32'hAAAA; exec_rd = 3; exec_rd_val = 32'hBBBB;
    set_dec(32'h8, 4'd3, 4'd3);
    cycle("fwd prio");
    check("fwd prio rs", rr_rs_val, 32'hAAAA);
    check("fwd prio rt", rr_rt_val, 32'hAAAA);
    exec_of_reg = 0; exec_of_val = 0; exec_rd = 0; exec_rd_val = 0;

    // Stall holds for three cycles while decode wiggles; r7 write still lands.
    set_dec(32'h20, 4'd3, 4'd5);
    cycle("pre stall");
    exec_stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_dec($urandom, 4'($urandom), 4'($urandom));
      if (i == 1) begin exec_rd = 7; exec_rd_val = 32'h7777; end
      else begin exec_rd = 0; exec_rd_val = 0; end
      cycle("stall");
      check("stall pc held", rr_pc, 32'h20);
    end
    exec_stall = 0; exec_rd = 0; exec_rd_val = 0;
    set_dec(32'h24, 4'd7, 4'd0);
    cycle("after stall");
    check("r7 landed", rr_rs_val, 32'h7777);

    // Flush squashes a valid decode; flush with stall holds.
    set_dec(32'h40, 4'd5, 4'd7);
    exec_flush = 1;
    cycle("flush");
    check("flush pc", rr_pc, 32'h0);
    exec_stall = 1;
    set_dec(32'h44, 4'd5, 4'd7);
    cycle("flush+stall");
    exec_stall = 0; exec_flush = 0;

    // Writes to r0 never take effect.
    dif.dec_valid = 0;
    exec_rd = 0; exec_rd_val = 32'hFFFF;
    cycle("wr r0");
    exec_rd_val = 0;
    set_dec(32'h48, 4'd0, 4'd0);
    cycle("read r0");
    check("r0 is zero", rr_rs_val, 32'h0);

    // Reset between edges while holding pc 0x10.
    set_dec(32'h10, 4'd5, 4'd7);
    cycle("load 0x10");
    check("holding 0x10", rr_pc, 32'h10);
    #2 i_reset = 1;
    m_reset();
    #1 check_all("mid reset");
    @(negedge i_clk);
    i_reset = 0;
    set_dec(32'h50, 4'd5, 4'd7);
    cycle("post reset read");
    check("r5 cleared", rr_rs_val, 32'h0);
    check("r7 cleared", rr_rt_val, 32'h0);

    // Random traffic with small register indices to provoke forwarding hits.
    for (int i = 0; i < 400; i++) begin
      exec_stall  = ($urandom_range(0, 3) == 0);
      exec_flush  = ($urandom_range(0, 3) == 0);
      exec_of_reg = 4'($urandom_range(0, 5));
      exec_of_val = $urandom;
      exec_rd     = 4'($urandom_range(0, 5));
      exec_rd_val = $urandom;
      set_dec($urandom, 4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)));
      dif.dec_valid = ($urandom_range(0, 3) != 0);
      cycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
